// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a 32-bit word RAM without byte enables.
// Sub-word stores use a read-modify-write sequence; bad requests never touch the RAM.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned BYTE_W = 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_e;

  state_e              state_q, state_d;
  logic                store_q, store_d;
  logic [2:0]          op_q, op_d;
  logic [1:0]          lane_q, lane_d;
  logic [HALF_W-1:0]   wdata_q, wdata_d;

  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;
  logic                ram_ce_q, ram_ce_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;

  logic [1:0]          req_size;
  logic                req_illegal;
  logic                req_misaligned;
  logic                req_out_of_range;
  logic                req_bad;
  logic [BYTE_W-1:0]   rd_byte;
  logic [HALF_W-1:0]   rd_half;
  logic [DATA_W-1:0]   load_val;
  logic [DATA_W-1:0]   merged;

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign ram_ce     = ram_ce_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;

  // Request legality: encoding, alignment and RAM range.
  always_comb begin
    req_size         = req_op[1:0];
    req_illegal      = (req_size == SZ_BAD) || (req_store && req_op[2]) ||
                       ((req_size == SZ_WORD) && req_op[2]);
    req_misaligned   = ((req_size == SZ_HALF) && req_addr[0]) ||
                       ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    req_out_of_range = |req_addr[31:ADDR_W+2];
    req_bad          = req_illegal || req_misaligned || req_out_of_range;
  end

  // Lane extraction with sign/zero extension, and lane merge for sub-word stores.
  always_comb begin
    rd_byte  = ram_rdata[{lane_q, 3'b000} +: BYTE_W];
    rd_half  = ram_rdata[{lane_q[1], 4'b0000} +: HALF_W];
    load_val = ram_rdata;
    case (op_q[1:0])
      SZ_BYTE: load_val = op_q[2] ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      SZ_HALF: load_val = op_q[2] ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_val = ram_rdata;
    endcase
    merged = ram_rdata;
    if (op_q[1:0] == SZ_BYTE) begin
      merged[{lane_q, 3'b000} +: BYTE_W] = wdata_q[BYTE_W-1:0];
    end else begin
      merged[{lane_q[1], 4'b0000} +: HALF_W] = wdata_q;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    op_d         = op_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    ram_ce_d     = ram_ce_q;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;

    case (state_q)
      S_IDLE: begin
        ram_ce_d = 1'b0;
        ram_we_d = 1'b0;
        if (req_valid) begin
          store_d     = req_store;
          op_d        = req_op;
          lane_d      = req_addr[1:0];
          wdata_d     = req_wdata[HALF_W-1:0];
          req_ready_d = 1'b0;
          if (req_bad) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            ram_ce_d   = 1'b1;
            ram_addr_d = req_addr[ADDR_W+1:2];
            if (req_store && (req_size == SZ_WORD)) begin
              state_d     = S_WR;
              ram_we_d    = 1'b1;
              ram_wdata_d = req_wdata;
            end else begin
              state_d  = S_RD;
              ram_we_d = 1'b0;
            end
          end
        end
      end
      S_RD: begin
        if (store_q) begin
          state_d     = S_WR;
          ram_we_d    = 1'b1;
          ram_wdata_d = merged;
        end else begin
          state_d      = S_RESP;
          ram_ce_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = load_val;
        end
      end
      S_WR: begin
        state_d      = S_RESP;
        ram_ce_d     = 1'b0;
        ram_we_d     = 1'b0;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end
      S_RESP: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        ram_ce_d    = 1'b0;
        ram_we_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any access and drops the RAM strobes at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      store_q      <= 1'b0;
      op_q         <= '0;
      lane_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      ram_ce_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      op_q         <= op_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      ram_ce_q     <= ram_ce_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word RAM model, reference memory and response scoreboard.
module tb_mem_access_unit;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 32;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_op;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              ram_ce;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ram_mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int          tests_run;
  int          tests_failed;
  int          ce_cnt;
  int          we_cnt;
  int          resp_cnt;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .ram_ce     (ram_ce),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: combinational read (returns wdata while writing), write on rising edge.
  assign ram_rdata = (ram_ce && ram_we) ? ram_wdata : ram_mem[ram_addr];
  always @(posedge clk) begin
    if (ram_ce && ram_we) ram_mem[ram_addr] <= ram_wdata;
  end

  // Activity counters sampled at each rising edge.
  always @(posedge clk) begin
    if (ram_ce) ce_cnt <= ce_cnt + 1;
    if (ram_ce && ram_we) we_cnt <= we_cnt + 1;
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = ref_mem[a[6:2]];
    b = 8'(w >> {a[1:0], 3'b000});
    h = 16'(w >> {a[1], 4'b0000});
    case (op)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  task automatic ref_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] w;
    logic [31:0] mask;
    logic [4:0]  sh;
    w = ref_mem[a[6:2]];
    if (op[1:0] == 2'b00) begin
      sh = {a[1:0], 3'b000};
      mask = 32'h0000_00FF << sh;
      w = (w & ~mask) | ((32'(d[7:0])) << sh);
    end else if (op[1:0] == 2'b01) begin
      sh = {a[1], 4'b0000};
      mask = 32'h0000_FFFF << sh;
      w = (w & ~mask) | ((32'(d[15:0])) << sh);
    end else begin
      w = d;
    end
    ref_mem[a[6:2]] = w;
  endtask

  // Present one request in an idle cycle; returns at the sample point of the cycle after accept.
  task automatic send(input logic st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1;
    req_store = st;
    req_op    = op;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for resp_valid; lat counts cycles after accept, -1 on timeout.
  task automatic get_resp(output logic [31:0] rd, output logic er, output int lat);
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    if (resp_valid !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    tests_run++;
    if ({resp_valid, resp_rdata, resp_err, ram_ce, ram_we} !== 35'h0) begin
      tests_failed++;
      $display("FAIL reset_resp_ram: got v=%b rd=%h e=%b ce=%b we=%b, want all 0",
               resp_valid, resp_rdata, resp_err, ram_ce, ram_we);
    end
    tests_run++;
    if (ram_addr !== '0 || ram_wdata !== 32'h0 || req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_addr_ready: got addr=%h wd=%h rdy=%b, want 0 0 1",
               ram_addr, ram_wdata, req_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sw_lw();
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          we0;
    exp_t        e;
    exp_t        got;
    we0 = we_cnt;
    sb.push_back('{rdata: 32'h0, err: 1'b0, lat: 8'd2});
    ref_store(3'b010, 32'h0C, 32'hDEADBEEF);
    send(1'b1, 3'b010, 32'h0C, 32'hDEADBEEF);
    tests_run++;
    if (ram_ce !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 5'd3 || ram_wdata !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL sw_wr_cycle: got ce=%b we=%b addr=%0d wd=%h, want 1 1 3 deadbeef",
               ram_ce, ram_we, ram_addr, ram_wdata);
    end
    get_resp(rd, er, lat);
    e = sb.pop_front();
    got = '{rdata: rd, err: er, lat: 8'(lat)};
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL sw_resp: got rd=%h err=%b lat=%0d, want rd=%h err=%b lat=%0d",
               rd, er, lat, e.rdata, e.err, e.lat);
    end
    tests_run++;
    if (we_cnt - we0 != 1) begin
      tests_failed++;
      $display("FAIL sw_we_count: got %0d write cycles, want 1", we_cnt - we0);
    end
    sb.push_back('{rdata: ref_load(3'b010, 32'h0C), err: 1'b0, lat: 8'd2});
    send(1'b0, 3'b010, 32'h0C, 32'h0);
    get_resp(rd, er, lat);
    e = sb.pop_front();
    got = '{rdata: rd, err: er, lat: 8'(lat)};
    tests_run++;
    if (got !== e || rd !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL lw_resp: got rd=%h err=%b lat=%0d, want rd=deadbeef err=0 lat=2",
               rd, er, lat);
    end
  endtask

  task automatic test_subword_store();
    logic [31:0] rd;
    logic        er;
    int          lat;
    exp_t        e;
    exp_t        got;
    ref_store(3'b010, 32'h0C, 32'h11223344);
    send(1'b1, 3'b010, 32'h0C, 32'h11223344);
    get_resp(rd, er, lat);
    // SB 0x0D: RD at T+1, WR at T+2, RESP at T+3.
    sb.push_back('{rdata: 32'h0, err: 1'b0, lat: 8'd1});
    ref_store(3'b000, 32'h0D, 32'h000000AA);
    send(1'b1, 3'b000, 32'h0D, 32'h000000AA);
    tests_run++;
    if (ram_ce !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 5'd3 || resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL sb_rd_cycle: got ce=%b we=%b addr=%0d v=%b, want 1 0 3 0",
               ram_ce, ram_we, ram_addr, resp_valid);
    end
    @(negedge clk);
    tests_run++;
    if (ram_ce !== 1'b1 || ram_we !== 1'b1 || ram_wdata !== 32'h1122AA44) begin
      tests_failed++;
      $display("FAIL sb_wr_cycle: got ce=%b we=%b wd=%h, want 1 1 1122aa44",
               ram_ce, ram_we, ram_wdata);
    end
    @(negedge clk);
    get_resp(rd, er, lat);
    e = sb.pop_front();
    got = '{rdata: rd, err: er, lat: 8'(lat)};
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL sb_resp_at_t3: got rd=%h err=%b extra=%0d, want rd=0 err=0 extra=1",
               rd, er, lat);
    end
    sb.push_back('{rdata: 32'h0, err: 1'b0, lat: 8'd3});
    ref_store(3'b001, 32'h0E, 32'h00005566);
    send(1'b1, 3'b001, 32'h0E, 32'h00005566);
    get_resp(rd, er, lat);
    e = sb.pop_front();
    got = '{rdata: rd, err: er, lat: 8'(lat)};
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL sh_resp: got rd=%h err=%b lat=%0d, want rd=0 err=0 lat=3", rd, er, lat);
    end
    sb.push_back('{rdata: ref_load(3'b010, 32'h0C), err: 1'b0, lat: 8'd2});
    send(1'b0, 3'b010, 32'h0C, 32'h0);
    get_resp(rd, er, lat);
    e = sb.pop_front();
    got = '{rdata: rd, err: er, lat: 8'(lat)};
    tests_run++;
    if (got !== e || rd !== 32'h5566AA44) begin
      tests_failed++;
      $display("FAIL sh_merged_word: got rd=%h err=%b lat=%0d, want 5566aa44 0 2", rd, er, lat);
    end
  endtask

  task automatic test_load_extend();
    logic [2:0]  ops  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] adrs [4] = '{32'h1, 32'h1, 32'h0, 32'h0};
    logic [31:0] want [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF807F, 32'h0000807F};
    logic [31:0] rd;
    logic        er;
    int          lat;
    exp_t        e;
    exp_t        got;
    ref_store(3'b010, 32'h0, 32'h0000807F);
    send(1'b1, 3'b010, 32'h0, 32'h0000807F);
    get_resp(rd, er, lat);
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{rdata: ref_load(ops[i], adrs[i]), err: 1'b0, lat: 8'd2});
      send(1'b0, ops[i], adrs[i], 32'h0);
      get_resp(rd, er, lat);
      e = sb.pop_front();
      got = '{rdata: rd, err: er, lat: 8'(lat)};
      tests_run++;
      if (got !== e || rd !== want[i]) begin
        tests_failed++;
        $display("FAIL load_ext_%0d op=%b: got rd=%h err=%b lat=%0d, want %h 0 2",
                 i, ops[i], rd, er, lat, want[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic        sts  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  ops  [4] = '{3'b001, 3'b010, 3'b010, 3'b011};
    logic [31:0] adrs [4] = '{32'h1, 32'h2, 32'h80, 32'h0};
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          ce0;
    exp_t        e;
    exp_t        got;
    ce0 = ce_cnt;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{rdata: 32'h0, err: 1'b1, lat: 8'd1});
      send(sts[i], ops[i], adrs[i], 32'hFFFFFFFF);
      get_resp(rd, er, lat);
      e = sb.pop_front();
      got = '{rdata: rd, err: er, lat: 8'(lat)};
      tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("FAIL err_case_%0d: got rd=%h err=%b lat=%0d, want rd=0 err=1 lat=1",
                 i, rd, er, lat);
      end
    end
    @(negedge clk);
    tests_run++;
    if (ce_cnt != ce0) begin
      tests_failed++;
      $display("FAIL err_no_ram_access: got %0d ce cycles, want 0", ce_cnt - ce0);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    @(negedge clk);
    sb.push_back('{rdata: ref_load(3'b010, 32'h0C), err: 1'b0, lat: 8'd2});
    sb.push_back('{rdata: ref_load(3'b010, 32'h00), err: 1'b0, lat: 8'd2});
    req_valid = 1'b1;
    req_store = 1'b0;
    req_op    = 3'b010;
    req_addr  = 32'h0C;
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h00;
    tests_run++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_rd: got rdy=%b v=%b, want 0 0", req_ready, resp_valid);
    end
    @(negedge clk);
    e = sb.pop_front();
    tests_run++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_rdata !== e.rdata || resp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_resp1: got rdy=%b v=%b rd=%h e=%b, want 0 1 %h 0",
               req_ready, resp_valid, resp_rdata, resp_err, e.rdata);
    end
    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_idle: got rdy=%b v=%b, want 1 0", req_ready, resp_valid);
    end
    @(negedge clk);
    req_valid = 1'b0;
    tests_run++;
    if (req_ready !== 1'b0 || ram_ce !== 1'b1 || ram_addr !== 5'd0) begin
      tests_failed++;
      $display("FAIL b2b_accept2: got rdy=%b ce=%b addr=%0d, want 0 1 0", req_ready, ram_ce, ram_addr);
    end
    @(negedge clk);
    e = sb.pop_front();
    tests_run++;
    if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || resp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_resp2: got v=%b rd=%h e=%b, want 1 %h 0", resp_valid, resp_rdata, resp_err, e.rdata);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          we0;
    int          rc0;
    exp_t        e;
    exp_t        got;
    send(1'b1, 3'b000, 32'h0, 32'h00000055);
    @(negedge clk);
    we0 = we_cnt;
    rc0 = resp_cnt;
    tests_run++;
    if (ram_we !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_in_wr: got we=%b, want 1", ram_we);
    end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (ram_we !== 1'b0 || ram_ce !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_we_drop: got we=%b ce=%b, want 0 0", ram_we, ram_ce);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1 || resp_cnt != rc0 || we_cnt != we0) begin
      tests_failed++;
      $display("FAIL rstmid_after: got rdy=%b resps=%0d writes=%0d, want 1 0 0",
               req_ready, resp_cnt - rc0, we_cnt - we0);
    end
    sb.push_back('{rdata: ref_load(3'b010, 32'h0), err: 1'b0, lat: 8'd2});
    send(1'b0, 3'b010, 32'h0, 32'h0);
    get_resp(rd, er, lat);
    e = sb.pop_front();
    got = '{rdata: rd, err: er, lat: 8'(lat)};
    tests_run++;
    if (got !== e || rd !== 32'h0000807F) begin
      tests_failed++;
      $display("FAIL rstmid_word_kept: got rd=%h err=%b lat=%0d, want 0000807f 0 2", rd, er, lat);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    ce_cnt       = 0;
    we_cnt       = 0;
    resp_cnt     = 0;
    req_valid    = 1'b0;
    req_store    = 1'b0;
    req_op       = 3'b000;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    test_reset();
    test_sw_lw();
    test_subword_store();
    test_load_extend();
    test_errors();
    test_back_to_back();
    test_reset_mid_write();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store unit between the MIPS MEM pipeline stage and the 32x32-bit word RAM. It accepts one byte-addressed request at a time (LB/LBU/LH/LHU/LW/SB/SH/SW). It drives the RAM's ce/we/addr/wdata and extracts and extends load data. The RAM has no byte enables, so sub-word stores are done as read-modify-write. Misaligned, out-of-range and illegal requests are flagged and make no RAM access.

Parameters:
ADDR_W, 5, RAM word-address width (RAM depth = 2**ADDR_W words); byte address bits [ADDR_W+1:2] select the word.

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept; high only in IDLE
req_store  in  1  1 = store, 0 = load
req_op  in  3  [1:0] size (00 byte, 01 half, 10 word); [2] = unsigned (loads only)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle completion pulse, no backpressure
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  request rejected; valid with resp_valid
ram_ce  out  1  to RAM ce
ram_we  out  1  to RAM we
ram_addr  out  ADDR_W  to RAM addr
ram_wdata  out  32  to RAM wdata
ram_rdata  in  32  from RAM rdata; combinational read, same cycle

Behaviour:
- Reset (async, immediate): state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, ram_ce=0, ram_we=0, ram_addr=0, ram_wdata=0. req_ready=1 once in IDLE.
- Accept on a rising edge with req_valid&&req_ready (cycle T). Latch store, op, addr, wdata. req_valid outside IDLE is ignored.
- Error check at accept:
  - illegal: size=11; store with op[2]=1; LW with op[2]=1
  - misaligned: half with addr[0]=1; word with addr[1:0]!=0
  - out-of-range: addr[31:ADDR_W+2]!=0
- States: IDLE, RD, WR, RESP.
  - Error: IDLE->RESP (resp_valid and resp_err at T+1). ram_ce stays 0.
  - Load: IDLE->RD(T+1)->RESP(T+2)->IDLE.
  - SW: IDLE->WR(T+1)->RESP(T+2)->IDLE.
  - SB/SH: IDLE->RD(T+1)->WR(T+2)->RESP(T+3)->IDLE.
- RD: ram_ce=1, ram_we=0 (we must stay 0 or the RAM returns wdata), ram_addr=word index. At the end of RD:
  - load: register the extracted result
  - sub-word store: register the merged word
- WR: ram_ce=1, ram_we=1, ram_addr=word index, ram_wdata = merged word (SB/SH) or req_wdata (SW). The RAM write lands on the edge ending WR.
- IDLE and RESP: ram_ce=0, ram_we=0, ram_addr and ram_wdata hold their last values.
- Lanes are little-endian.
  - Byte k=addr[1:0] occupies bits [8k+7:8k].
  - Half h=addr[1] occupies bits [16h+15:16h].
  - Merge replaces only the addressed lane with req_wdata[7:0] or [15:0]; all other bits come from ram_rdata.
- Extension: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- resp_valid is high for exactly one cycle (RESP). resp_rdata/resp_err hold until the next RESP; resp_rdata=0 for stores.
- Throughput: next accept no earlier than the cycle after RESP. Back-to-back loads issue every 3 cycles.
- Reset mid-operation: state returns to IDLE immediately and ram_we drops. A write occurs only if rst_n is high at the edge ending WR. No response is issued for the aborted request.

Test Plan:
- SW addr 0x0C data 0xDEADBEEF, then LW 0x0C -> ram_we=1 only at T+1 with ram_addr=3. Store resp at T+2; load resp_rdata=0xDEADBEEF, err=0, at T+2 of its accept.
- Word 3=0x11223344; SB 0x0D data 0xAA -> RD at T+1, WR at T+2 with ram_wdata=0x1122AA44, resp at T+3. Then SH 0x0E data 0x5566 -> 0x5566AA44.
- Word 0=0x0000807F: LB 0x1 -> 0xFFFFFF80; LBU 0x1 -> 0x00000080; LH 0x0 -> 0xFFFF807F; LHU 0x0 -> 0x0000807F.
- LH 0x1, SW 0x2, LW 0x80, op size=11 -> each gives resp_valid/resp_err=1 at T+1, resp_rdata=0. ram_ce stays 0 throughout.
- req_valid held high continuously over two loads -> second accept exactly one cycle after first RESP; req_ready=0 in RD/RESP.
- SB accepted, rst_n pulled low during WR, before the edge -> ram_we falls immediately, RAM word unchanged, no resp_valid, req_ready=1 after release.
